// File: rtl/pin_uart_pkg.sv
// Shared types and helpers for the pin-tap serial receiver (and a later transmitter).
package pin_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned MID            = DEF_OVERSAMPLE / 2;

  // Nearest-integer clock divider per sample tick, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    int unsigned rate;
    int unsigned d;
    rate = baud * oversample;
    d    = (clk_hz + rate / 2) / rate;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/pin_uart_fifo.sv
// Small synchronous FIFO; head is the oldest entry, no write-to-read bypass.
module pin_uart_fifo
  import pin_uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_cog,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head that is leaving this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_cog) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pin_uart_rx.sv
// 8N1 receiver tapping a Propeller pin: oversampled majority-vote bit recovery into a FIFO.
module pin_uart_rx
  import pin_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 80_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_cog,
  input  logic       res,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DW    = $clog2(DIV + 1);
  localparam int unsigned OW    = $clog2(OVERSAMPLE);
  localparam int unsigned S_MID = OVERSAMPLE / 2;

  rx_state_t state, state_nx;

  logic [1:0]    sync;
  logic          line;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic [2:0]    bit_cnt;
  logic          s0, s1;
  logic          maj;
  logic          tick, bit_end, decide;
  logic [7:0]    shreg;
  logic          push_req, ferr_set, ovr_set;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_head;

  assign line    = sync[1] | ~rx_en;
  assign tick    = (div_cnt == DW'(DIV - 1));
  assign bit_end = tick && (os_cnt == OW'(OVERSAMPLE - 1));
  assign decide  = tick && (os_cnt == OW'(S_MID + 1));
  assign maj     = (s0 & s1) | (s0 & line) | (s1 & line);

  always_ff @(posedge clk_cog) begin
    if (res) begin
      sync  <= '1;
      state <= IDLE;
    end else begin
      sync  <= {sync[0], rx};
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE:  if (!line) state_nx = START;
      START: begin
        if (decide && maj) state_nx = IDLE;
        else if (bit_end)  state_nx = DATA;
      end
      DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
      STOP: begin
        if (decide) begin
          if (maj) begin
            push_req = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_nx = BREAK;
          end
        end
      end
      BREAK: if (line) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!rx_en) begin
      state_nx = IDLE;
      push_req = 1'b0;
      ferr_set = 1'b0;
    end
  end

  // Holding the counters at zero in IDLE aligns the tick phase to the start edge.
  always_ff @(posedge clk_cog) begin
    if (res || state == IDLE) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      if (bit_end && state == DATA) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_cog) begin
    if (res) begin
      s0    <= 1'b1;
      s1    <= 1'b1;
      shreg <= '0;
    end else begin
      if (tick && os_cnt == OW'(S_MID - 1)) s0 <= line;
      if (tick && os_cnt == OW'(S_MID))     s1 <= line;
      if (decide && state == DATA)          shreg <= {maj, shreg[7:1]};
    end
  end

  assign pop     = valid & ready;
  assign ovr_set = push_req & fifo_full & ~pop;

  always_ff @(posedge clk_cog) begin
    if (res) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~clr_err);
      overrun   <= ovr_set  | (overrun   & ~clr_err);
    end
  end

  pin_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_cog (clk_cog),
    .res     (res),
    .push    (push_req),
    .wdata   (shreg),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign valid = ~fifo_empty;
  assign data  = fifo_empty ? '0 : fifo_head;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pin_uart_rx.sv
// Directed bench for pin_uart_rx at DIV=10, 160 cycles per bit.
module tb_pin_uart_rx;

  localparam int unsigned BIT = 160;

  logic       clk_cog = 1'b0;
  logic       res     = 1'b1;
  logic       rx      = 1'b1;
  logic       rx_en   = 1'b1;
  logic       ready   = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       valid, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] rxq [$];

  pin_uart_rx #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_cog   (clk_cog),
    .res       (res),
    .rx        (rx),
    .rx_en     (rx_en),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  always #5 clk_cog = ~clk_cog;

  always @(posedge clk_cog) if (valid && ready) rxq.push_back(data);

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_cog);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      wait_cyc(BIT);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bits(b, 8);
    rx = stop_bit;
    wait_cyc(BIT);
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_reset;
    res = 1'b1;
    wait_cyc(4);
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (data !== 8'h00)     begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    res = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_basic;
    logic seen = 1'b0;
    logic vbusy = 1'b1;
    logic [7:0] vdata = '0;
    ready = 1'b1;
    rxq.delete();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 1700 && !seen; i++) begin
          @(negedge clk_cog);
          if (valid) begin seen = 1'b1; vbusy = busy; vdata = data; end
        end
      end
    join
    checks++; if (seen !== 1'b1)      begin errors++; $display("FAIL basic_valid_seen: got %b want 1", seen); end
    checks++; if (vdata !== 8'hA5)    begin errors++; $display("FAIL basic_data_at_valid: got %h want a5", vdata); end
    checks++; if (vbusy !== 1'b0)     begin errors++; $display("FAIL basic_busy_at_valid: got %b want 0", vbusy); end
    checks++; if (rxq.size() != 1)    begin errors++; $display("FAIL basic_count: got %0d want 1", rxq.size()); end
    else begin
      checks++; if (rxq[0] !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %h want a5", rxq[0]); end
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_glitch;
    rxq.delete();
    rx = 1'b0;
    wait_cyc(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(100);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    wait_cyc(200);
    checks++; if (rxq.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL glitch_no_byte: got %0d bytes valid %b want 0", rxq.size(), valid); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b want 00", {frame_err, overrun}); end
  endtask

  task automatic test_break;
    rxq.delete();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_cyc(3200);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", frame_err); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL break_busy: got %b want 1", busy); end
    checks++; if (rxq.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL break_no_byte: got %0d bytes want 0", rxq.size()); end
    rx = 1'b1;
    wait_cyc(20);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL break_release: got %b want 0", busy); end
    send_frame(8'h11, 1'b1);
    wait_cyc(20);
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h11) begin errors++; $display("FAIL break_next_byte: got %0d bytes want one 11", rxq.size()); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_ferr_sticky: got %b want 1", frame_err); end
    pulse_clr();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL break_clr: got %b want 0", frame_err); end
  endtask

  task automatic test_back_to_back;
    ready = 1'b0;
    rxq.delete();
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1);
    checks++; if (valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_four: got valid %b ovr %b want 1 0", valid, overrun); end
    send_frame(8'h05, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    checks++; if (data !== 8'h01)   begin errors++; $display("FAIL b2b_head_stable: got %h want 01", data); end
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (valid !== 1'b1 || data !== 8'(k)) begin errors++; $display("FAIL b2b_read%0d: got valid %b data %h want 1 %h", k, valid, data, 8'(k)); end
      wait_cyc(1);
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", valid); end
    pulse_clr();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr: got %b want 0", overrun); end
  endtask

  task automatic test_rx_en;
    ready = 1'b1;
    rxq.delete();
    send_bits(8'h7E, 3);
    rx = 1'b1;
    wait_cyc(BIT / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rxen_busy_before: got %b want 1", busy); end
    rx_en = 1'b0;
    wait_cyc(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rxen_busy_after: got %b want 0", busy); end
    wait_cyc(BIT * 6);
    rx_en = 1'b1;
    wait_cyc(20);
    checks++; if (rxq.size() != 0 || {frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL rxen_quiet: got %0d bytes flags %b want 0 00", rxq.size(), {frame_err, overrun}); end
    send_frame(8'h7E, 1'b1);
    wait_cyc(10);
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h7E) begin errors++; $display("FAIL rxen_resume: got %0d bytes want one 7e", rxq.size()); end
  endtask

  task automatic test_mid_reset;
    ready = 1'b0;
    rxq.delete();
    send_frame(8'h21, 1'b1);
    send_frame(8'h22, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h21) begin errors++; $display("FAIL mres_pre: got valid %b data %h want 1 21", valid, data); end
    // Bits 3..7 of F8 are high, so the tail after reset cannot look like a start bit.
    send_bits(8'hF8, 3);
    rx = 1'b1;
    wait_cyc(BIT / 2);
    res = 1'b1;
    wait_cyc(1);
    res = 1'b0;
    checks++; if ({valid, busy, frame_err, overrun} !== 4'b0000) begin errors++; $display("FAIL mres_clear: got %b want 0000", {valid, busy, frame_err, overrun}); end
    wait_cyc(BIT * 6);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mres_tail_dropped: got %b want 0", valid); end
    send_frame(8'h5A, 1'b1);
    checks++; if (valid !== 1'b1 || data !== 8'h5A) begin errors++; $display("FAIL mres_next: got valid %b data %h want 1 5a", valid, data); end
    ready = 1'b1;
    wait_cyc(2);
    checks++; if (rxq.size() != 1 || valid !== 1'b0) begin errors++; $display("FAIL mres_pop: got %0d bytes valid %b want 1 0", rxq.size(), valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_back_to_back();
    test_rx_en();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
